// File: rtl/mux_pkg.sv
// mux_pkg: mode encoding and output reset constant shared by mux_reg_mnton and its bench.
package mux_pkg;
  typedef enum logic {MUX_MODE_SEL = 1'b0, MUX_MODE_RR = 1'b1} mux_mode_e;
  localparam logic OUT_DATA_RST = 1'b0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority search starting at ptr, wrapping mod M.
module rr_arbiter #(
  parameter int M = 4,
  localparam int SW = $clog2(M)
) (
  input  logic [M-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);
  logic [SW:0]   sum;
  logic [SW-1:0] idx;
  // Scan from farthest to nearest so the request closest to ptr is written last and wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = M - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (SW + 1)'(k);
      idx = (sum >= (SW + 1)'(M)) ? SW'(sum - (SW + 1)'(M)) : SW'(sum);
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end
endmodule

// File: rtl/mux_reg_mnton.sv
// mux_reg_mnton: registered M:1 mux with valid/ready handshake; define MUX_RR_EN to
// honour mode and add the round-robin arbiter with its rr_ptr register.
module mux_reg_mnton
  import mux_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 4,
  localparam int SW = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           mode,
  input  logic [SW-1:0]  S,
  input  logic [M*N-1:0] in_data,
  input  logic [M-1:0]   in_valid,
  output logic [M-1:0]   in_ready,
  output logic [N-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_sel
);
  localparam logic [N-1:0] DATA_ZERO = {N{OUT_DATA_RST}};
  logic [N-1:0]  ch [M];
  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic [SW-1:0] grant_idx;
  logic          grant_any, sel_ok, space, accept;
  for (genvar g = 0; g < M; g++) begin : g_ch
    assign ch[g] = in_data[g*N +: N];
  end
  assign sel_ok = (int'(S) < M) ? in_valid[S] : 1'b0;
`ifdef MUX_RR_EN
  logic [SW-1:0] rr_ptr_q, rr_ptr_d, rr_idx;
  logic          rr_any, rr_mode;
  rr_arbiter #(.M(M)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );
  assign rr_mode = mux_mode_e'(mode) == MUX_MODE_RR;
  always_comb begin
    grant_idx = rr_mode ? rr_idx : S;
    grant_any = rr_mode ? rr_any : sel_ok;
    rr_ptr_d = (accept && rr_mode) ? ((grant_idx == SW'(M - 1)) ? '0 : grant_idx + 1'b1) : rr_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else if (en) rr_ptr_q <= rr_ptr_d;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  always_comb begin
    grant_idx = S;
    grant_any = sel_ok;
  end
`endif
  assign space    = en && (!out_valid_q || out_ready);
  assign accept   = space && grant_any;
  assign in_ready = accept ? (M'(1) << grant_idx) : '0;
  // Whenever the next state is not valid the word is cleared, keeping out_data=0 while idle.
  always_comb begin
    out_valid_d = en && (accept || (out_valid_q && !out_ready));
    out_data_d = accept ? ch[grant_idx] : out_valid_d ? out_data_q : DATA_ZERO;
    out_sel_d = accept ? grant_idx : out_sel_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q <= DATA_ZERO;
      out_valid_q <= 1'b0;
      out_sel_q <= '0;
    end else begin
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sel_q <= out_sel_d;
    end
  end
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
endmodule
